// File: rtl/img_stream_gen.sv
// img_stream_gen
//   Test-pattern image source. Emits frames of IMG_HDISP x IMG_VDISP 8-bit
//   pixels on the per_img_vsync / per_img_href / per_img_gray interface, with
//   programmable lead, per-row, tail and inter-frame blanking.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   start           one-frame request, only honoured while idle
//   cont_en         repeat frames back-to-back while high
//   pat_mode[1:0]   pattern select, latched at each frame start
//   busy            high from first vsync cycle through last gap cycle
//   frame_done      one-cycle pulse on the last gap cycle
//   frame_cnt[7:0]  completed frames, wraps at 256
//   per_img_vsync   frame valid
//   per_img_href    pixel valid
//   per_img_gray    pixel value, 0 while href is low
//
// Frame layout (vsync high for V_LEAD + IMG_VDISP*(H_BLANK+IMG_HDISP) + V_TAIL):
//   LEAD -> { HBLK -> ACTIVE } x IMG_VDISP -> TAIL -> GAP (vsync low)
module img_stream_gen #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 10,
    parameter int V_LEAD    = 5,
    parameter int V_TAIL    = 1,
    parameter int V_GAP     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont_en,
    input  logic [1:0] pat_mode,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       per_img_vsync,
    output logic       per_img_href,
    output logic [7:0] per_img_gray
);

    localparam int CW   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int RW   = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam int M1   = (V_LEAD > H_BLANK) ? V_LEAD : H_BLANK;
    localparam int M2   = (V_TAIL > V_GAP) ? V_TAIL : V_GAP;
    localparam int PMAX = (M1 > M2) ? M1 : M2;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    typedef enum logic [2:0] {IDLE, LEAD, HBLK, ACTIVE, TAIL, GAP} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;   // cycle count within a blanking phase
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n;
    logic [1:0]    mode, mode_n;
    logic [7:0]    fcnt_n;
    logic          done_n;
    logic [7:0]    col8, row8, pix;

    // Next-state and next-counter values. Outputs are registered from these,
    // so each output cycle reflects the state it belongs to with no lag.
    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        col_n   = col;
        row_n   = row;
        mode_n  = mode;
        fcnt_n  = frame_cnt;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start || cont_en) begin
                    state_n = LEAD;
                    pcnt_n  = '0;
                    col_n   = '0;
                    row_n   = '0;
                    mode_n  = pat_mode;
                end
            end
            LEAD: begin
                if (pcnt == PW'(V_LEAD - 1)) begin
                    state_n = HBLK;
                    pcnt_n  = '0;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            HBLK: begin
                if (pcnt == PW'(H_BLANK - 1)) begin
                    state_n = ACTIVE;
                    col_n   = '0;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            ACTIVE: begin
                if (col == CW'(IMG_HDISP - 1)) begin
                    pcnt_n = '0;
                    if (row == RW'(IMG_VDISP - 1)) begin
                        state_n = TAIL;
                    end else begin
                        state_n = HBLK;
                        row_n   = row + 1'b1;
                    end
                end else begin
                    col_n = col + 1'b1;
                end
            end
            TAIL: begin
                if (pcnt == PW'(V_TAIL - 1)) begin
                    state_n = GAP;
                    pcnt_n  = '0;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            GAP: begin
                if (pcnt == PW'(V_GAP - 1)) begin
                    pcnt_n = '0;
                    col_n  = '0;
                    row_n  = '0;
                    if (cont_en) begin
                        state_n = LEAD;
                        mode_n  = pat_mode;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // The cycle being entered is the last gap cycle: pulse done and count
        // the frame in that same cycle.
        if (state_n == GAP && pcnt_n == PW'(V_GAP - 1)) begin
            done_n = 1'b1;
            fcnt_n = frame_cnt + 1'b1;
        end
    end

    // Pixel for the cycle being entered.
    always_comb begin
        col8 = 8'(col_n);
        row8 = 8'(row_n);
        case (mode_n)
            2'd0:    pix = col8;
            2'd1:    pix = row8;
            2'd2:    pix = (col8[3] ^ row8[3]) ? 8'hFF : 8'h00;
            default: pix = col8 + row8 + fcnt_n;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pcnt          <= '0;
            col           <= '0;
            row           <= '0;
            mode          <= '0;
            frame_cnt     <= '0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            per_img_vsync <= 1'b0;
            per_img_href  <= 1'b0;
            per_img_gray  <= '0;
        end else begin
            state         <= state_n;
            pcnt          <= pcnt_n;
            col           <= col_n;
            row           <= row_n;
            mode          <= mode_n;
            frame_cnt     <= fcnt_n;
            frame_done    <= done_n;
            busy          <= (state_n != IDLE);
            per_img_vsync <= (state_n == LEAD) || (state_n == HBLK) ||
                             (state_n == ACTIVE) || (state_n == TAIL);
            per_img_href  <= (state_n == ACTIVE);
            per_img_gray  <= (state_n == ACTIVE) ? pix : 8'h00;
        end
    end

endmodule

// File: tb/tb_img_stream_gen.sv
// Bench for img_stream_gen. Two instances: a tiny frame (4x3) for timing and
// sequencing scenarios plus randomized traffic, and a 640-wide frame for the
// checkerboard pattern. A frame-level reference model predicts every output
// of both instances on every cycle; literal expectations pin the model.
module tb_img_stream_gen;

    localparam int BV = 16;  // rows of the wide instance, kept small for runtime

    typedef struct {int hd; int vd; int hb; int vl; int vt; int vg;} cfg_t;
    typedef struct {bit act; int k; int mode; int fc;} mdl_t;

    logic clk = 0;
    logic rst_n = 0;
    logic startA = 0, contA = 0, startB = 0, contB = 0;
    logic [1:0] pmA = 0, pmB = 0;
    logic bA, dA, vsA, hrA, bB, dB, vsB, hrB;
    logic [7:0] fA, gA, fB, gB;

    always #5 clk = ~clk;

    img_stream_gen #(.IMG_HDISP(4), .IMG_VDISP(3), .H_BLANK(2), .V_LEAD(3),
                     .V_TAIL(1), .V_GAP(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(startA), .cont_en(contA),
        .pat_mode(pmA), .busy(bA), .frame_done(dA), .frame_cnt(fA),
        .per_img_vsync(vsA), .per_img_href(hrA), .per_img_gray(gA));

    img_stream_gen #(.IMG_HDISP(640), .IMG_VDISP(BV)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(startB), .cont_en(contB),
        .pat_mode(pmB), .busy(bB), .frame_done(dB), .frame_cnt(fB),
        .per_img_vsync(vsB), .per_img_href(hrB), .per_img_gray(gB));

    cfg_t cfgA = '{4, 3, 2, 3, 1, 2};
    cfg_t cfgB = '{640, BV, 10, 5, 1, 10};
    mdl_t mA = '{0, 0, 0, 0};
    mdl_t mB = '{0, 0, 0, 0};

    int  errors = 0;
    int  checks = 0;
    bit  chk_on = 0;
    int  cyc = 0;

    function automatic int frame_len(cfg_t c);
        return c.vl + c.vd * (c.hb + c.hd) + c.vt + c.vg;
    endfunction

    // Frame-level model: k is the 1-based cycle index within the current frame.
    function automatic mdl_t step(mdl_t m, cfg_t c, bit rn, bit st, bit ce, int pm);
        mdl_t r = m;
        int tot = frame_len(c);
        if (!rn) begin
            r.act = 0; r.k = 0; r.mode = 0; r.fc = 0;
        end else if (!m.act) begin
            if (st || ce) begin r.act = 1; r.k = 1; r.mode = pm; end
        end else if (m.k == tot) begin
            if (ce) begin r.k = 1; r.mode = pm; end
            else begin r.act = 0; r.k = 0; end
        end else begin
            r.k = m.k + 1;
            if (r.k == tot) r.fc = (m.fc + 1) % 256;
        end
        return r;
    endfunction

    function automatic logic [7:0] pix(int md, int row, int col, int fc);
        case (md)
            0:       return 8'(col % 256);
            1:       return 8'(row % 256);
            2:       return ((((col / 8) ^ (row / 8)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return 8'((col + row + fc) % 256);
        endcase
    endfunction

    // {vsync, href, gray, busy, frame_done, frame_cnt}
    function automatic logic [19:0] expv(mdl_t m, cfg_t c);
        int L, j, t, row, col;
        bit vs, hr, dn;
        logic [7:0] g;
        vs = 0; hr = 0; dn = 0; g = 0;
        if (!m.act) return {12'b0, 8'(m.fc)};
        L = c.hb + c.hd;
        if (m.k <= c.vl) vs = 1;
        else begin
            j = m.k - c.vl - 1;
            if (j < c.vd * L) begin
                vs  = 1;
                row = j / L;
                col = (j % L) - c.hb;
                if (col >= 0) begin hr = 1; g = pix(m.mode, row, col, m.fc); end
            end else begin
                t = j - c.vd * L;
                if (t < c.vt) vs = 1;
                else dn = (m.k == frame_len(c));
            end
        end
        return {vs, hr, g, 1'b1, dn, 8'(m.fc)};
    endfunction

    always @(posedge clk) begin
        mA <= step(mA, cfgA, rst_n, startA, contA, int'(pmA));
        mB <= step(mB, cfgB, rst_n, startB, contB, int'(pmB));
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({vsA, hrA, gA, bA, dA, fA} !== expv(mA, cfgA)) begin
                errors++;
                $display("FAIL streamA cyc=%0d got=%h expected=%h", cyc,
                         {vsA, hrA, gA, bA, dA, fA}, expv(mA, cfgA));
            end
            checks++;
            if ({vsB, hrB, gB, bB, dB, fB} !== expv(mB, cfgB)) begin
                errors++;
                $display("FAIL streamB cyc=%0d got=%h expected=%h", cyc,
                         {vsB, hrB, gB, bB, dB, fB}, expv(mB, cfgB));
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Captured samples of instance A; index 1 is the cycle after start is sampled.
    bit va[0:127], ha[0:127], ba[0:127], da[0:127];
    int ga[0:127], fa[0:127];
    int ncap = 0;

    task automatic frame_a(input int md, input bit ce, input int n, input int drop_at,
                           input int pulse_at, input int npm, input int rst_at);
        startA = 1; pmA = 2'(md); contA = ce;
        @(posedge clk); #1 startA = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            va[i] = vsA; ha[i] = hrA; ga[i] = gA; ba[i] = bA; da[i] = dA; fa[i] = fA;
            @(posedge clk); #1;
            startA = (i == pulse_at);
            if (i == pulse_at) pmA = 2'(npm);
            if (i == drop_at) contA = 0;
            rst_n = (i != rst_at);
        end
        ncap = n;
    endtask

    task automatic sums(output int nv, output int nh, output int nd, output int ngz);
        nv = 0; nh = 0; nd = 0; ngz = 0;
        for (int i = 1; i <= ncap; i++) begin
            nv += va[i]; nh += ha[i]; nd += da[i];
            if (!ha[i] && ga[i] != 0) ngz++;
        end
    endtask

    function automatic int row4(int s);
        return (ga[s] << 24) | (ga[s+1] << 16) | (ga[s+2] << 8) | ga[s+3];
    endfunction

    initial begin
        int nv, nh, nd, ngz, hc, r, c, g0, g8, g80, g88, gd;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; chk_on = 1;
        @(negedge clk);
        chk("reset vsync", vsA, 0);
        chk("reset busy", bA, 0);
        chk("reset frame_cnt", fA, 0);
        @(posedge clk); #1;

        // single frame, column ramp
        frame_a(0, 0, 30, 0, 0, 0, 0);
        sums(nv, nh, nd, ngz);
        chk("m0 vsync cycles", nv, 22);
        chk("m0 vsync first", va[1], 1);
        chk("m0 vsync after tail", va[23], 0);
        chk("m0 href cycles", nh, 12);
        chk("m0 href first", ha[6] && !ha[5], 1);
        chk("m0 href row2 end", ha[21] && !ha[22], 1);
        chk("m0 row2 gray", row4(18), 32'h00010203);
        chk("m0 done at 24", da[24], 1);
        chk("m0 done count", nd, 1);
        chk("m0 frame_cnt", fa[24], 1);
        chk("m0 idle after", ba[25], 0);

        // single frame, row ramp
        frame_a(1, 0, 30, 0, 0, 0, 0);
        sums(nv, nh, nd, ngz);
        chk("m1 row0", row4(6), 32'h00000000);
        chk("m1 row1", row4(12), 32'h01010101);
        chk("m1 row2", row4(18), 32'h02020202);
        chk("m1 gray zero off href", ngz, 0);

        // continuous mode from a fresh counter, dropped during frame 3
        rst_n = 0; @(posedge clk); #1 rst_n = 1;
        frame_a(3, 1, 76, 60, 35, 3, 0);
        chk("cont f1 px00", ga[6], 0);
        chk("cont f2 vsync after done", va[25] && da[24], 1);
        chk("cont f2 px00", ga[30], 1);
        chk("cont f3 px00", ga[54], 2);
        chk("cont f3 frame_cnt", fa[72], 3);
        chk("cont idle after drop", ba[73], 0);

        // start and pattern change mid-frame have no effect
        frame_a(0, 0, 30, 0, 10, 2, 0);
        sums(nv, nh, nd, ngz);
        chk("mid vsync cycles", nv, 22);
        chk("mid done count", nd, 1);
        chk("mid done at 24", da[24], 1);
        chk("mid row2 gray", row4(18), 32'h00010203);
        chk("mid idle after", ba[25], 0);

        // reset during row 1, then a clean frame
        frame_a(0, 0, 20, 0, 0, 0, 11);
        chk("rst href before", ha[12], 1);
        chk("rst outputs cleared", {va[13], ha[13], ba[13]}, 0);
        chk("rst gray", ga[13], 0);
        chk("rst frame_cnt", fa[13], 0);
        frame_a(0, 0, 30, 0, 0, 0, 0);
        sums(nv, nh, nd, ngz);
        chk("post-rst vsync cycles", nv, 22);
        chk("post-rst done at 24", da[24], 1);
        chk("post-rst frame_cnt", fa[24], 1);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rst_n  = ($urandom_range(0, 99) != 0);
            startA = ($urandom_range(0, 7) == 0);
            pmA    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) contA = ~contA;
        end
        rst_n = 1; startA = 0; contA = 0;
        repeat (40) @(posedge clk);
        #1;

        // wide instance, checkerboard
        startB = 1; pmB = 2;
        @(posedge clk); #1 startB = 0;
        hc = 0; gd = 0; g0 = -1; g8 = -1; g80 = -1; g88 = -1;
        for (int i = 0; i < 14000 && gd == 0; i++) begin
            @(negedge clk);
            if (hrB) begin
                r = hc / 640; c = hc % 640;
                if (r == 0 && c == 0) g0 = gB;
                if (r == 0 && c == 8) g8 = gB;
                if (r == 8 && c == 0) g80 = gB;
                if (r == 8 && c == 8) g88 = gB;
                hc++;
            end
            if (dB) gd = 1;
        end
        chk("B frame_done seen", gd, 1);
        chk("B href count", hc, 640 * BV);
        chk("B r0c0", g0, 8'h00);
        chk("B r0c8", g8, 8'hFF);
        chk("B r8c0", g80, 8'hFF);
        chk("B r8c8", g88, 8'h00);
        @(posedge clk); #1;
        chk_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_stream_gen.md
Name: img_stream_gen

Overview:
- Synthesizable image-stream transmitter. Drives the per_img_vsync / per_img_href / per_img_gray pixel interface consumed by the filter blocks (gaussian_filter_proc and siblings).
- Generates frames of IMG_HDISP x IMG_VDISP 8-bit pixels from built-in test patterns, with programmable blanking.
- Replaces file-driven stimulus on hardware. Provides a deterministic frame source for board bring-up and self-checking simulation.

Parameters:
- IMG_HDISP, 640: active pixels per row.
- IMG_VDISP, 480: active rows per frame.
- H_BLANK, 10: href-low cycles before each row, vsync high (>=1).
- V_LEAD, 5: vsync-high, href-low cycles at frame start, before the first row's H_BLANK (>=1).
- V_TAIL, 1: vsync-high, href-low cycles after the last pixel (>=1).
- V_GAP, 10: vsync-low cycles between frames (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request for one frame; honoured only in IDLE.
- cont_en  in  1  continuous mode: while high, frames repeat back-to-back.
- pat_mode  in  2  pattern select; sampled at frame start.
- busy  out  1  high from the frame's first vsync cycle through the last V_GAP cycle.
- frame_done  out  1  one-cycle pulse on the last V_GAP cycle.
- frame_cnt  out  8  completed-frame counter; wraps 255->0.
- per_img_vsync  out  1  frame valid.
- per_img_href  out  1  pixel valid.
- per_img_gray  out  8  pixel data; 0 when href is low.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, row/col counters 0, frame_cnt 0. Applies on any edge with rst_n=0, including mid-frame. The next cycle drives vsync=0, href=0.
- All outputs are registered.
- FSM states: IDLE, LEAD, HBLK, ACTIVE, TAIL, GAP.
- IDLE: if start or cont_en is high at edge T, latch pat_mode and go to LEAD. vsync=1 from T+1.
- LEAD: V_LEAD cycles, vsync=1, href=0 -> HBLK.
- HBLK: H_BLANK cycles, vsync=1, href=0 -> ACTIVE.
- ACTIVE: IMG_HDISP cycles, href=1, col 0..IMG_HDISP-1.
  - At the end of a row: if row < IMG_VDISP-1, increment row and go to HBLK; otherwise go to TAIL.
- TAIL: V_TAIL cycles, vsync=1, href=0 -> GAP.
- GAP: V_GAP cycles, vsync=0, href=0.
  - The last GAP cycle asserts frame_done and increments frame_cnt.
  - Next state: LEAD if cont_en=1 (pat_mode re-latched), else IDLE.
- Cycles per frame with vsync=1: V_LEAD + IMG_VDISP*(H_BLANK+IMG_HDISP) + V_TAIL.
- Pixel value per pattern (row/col are the current counters; latched mode):
  - 0: col[7:0].
  - 1: row[7:0].
  - 2: 8'hFF if (col[3]^row[3]), else 8'h00.
  - 3: (col+row+frame_cnt) mod 256.
- start outside IDLE is ignored; it is not queued.
- start and cont_en high together in IDLE start one frame; continuous mode then follows cont_en.
- cont_en dropped mid-frame: the current frame completes, then the FSM returns to IDLE.
- pat_mode changes mid-frame have no effect until the next frame start.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit. No overflow is possible within a frame.

Test Plan:
- Params HDISP=4, VDISP=3, H_BLANK=2, V_LEAD=3, V_TAIL=1, V_GAP=2; start pulse at cycle 0, mode 0 -> vsync high cycles 1..22 (22 cycles); href high cycles 6-9, 12-15, 18-21; gray 0,1,2,3 each row; frame_done at cycle 24; frame_cnt=1; return to IDLE.
- Same params, mode 1 -> gray rows 0,0,0,0 / 1,1,1,1 / 2,2,2,2; gray=0 whenever href=0.
- Default 640x480, mode 2 -> row 0: cols 0-7 = 00, cols 8-15 = FF; row 8: cols 0-7 = FF; exactly 307200 href cycles per frame.
- cont_en=1 for 3 frames, mode 3 -> next vsync rises 1 cycle after each frame_done; frame 2 pixel(0,0)=1, frame 3 pixel(0,0)=2; cont_en low during frame 3 -> IDLE after its GAP.
- start pulsed mid-frame and pat_mode changed mid-frame -> no extra frame and no pattern change in the current frame; frame timing identical to the single-frame case.
- rst_n low for 1 cycle during ACTIVE row 1 -> vsync/href/gray/busy = 0 next cycle; frame_cnt=0; the next start produces a full, correctly timed frame.
